hazard_scoreboard: RTL

Parametrised hazard controller for the five-stage MIPS pipeline. It generalises the Tuse/Tnew stall-and-forward unit in three ways: it owns a shadow pipeline of destination, write-enable and Tnew for E/M/W, it tracks a multi-cycle multiply/divide unit with a busy counter, and it suppresses all hazards on register 0. It sits beside the D/E/M/W pipeline registers. It drives stall to PC/IF-ID, bubble to ID-EX, and forward selects to the D, E and M operand muxes.

---
 rtl/hazard_pkg.sv | 52 +++++
 rtl/md_busy_counter.sv | 29 ++
 rtl/hazard_scoreboard.sv | 128 ++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types, forward-select codes and helper functions for the
// hazard scoreboard and its bench.
package hazard_pkg;

    // Shadow-stage fields are stored at these widths; the scoreboard's REG_AW and
    // TNEW_W must not exceed them.
    localparam int unsigned REG_AW_MAX = 8;
    localparam int unsigned TNEW_W_MAX = 4;

    localparam logic [1:0] TUSE_NONE = '1;

    typedef enum logic [1:0] {
        FWD_SELF = 2'd0,
        FWD_W    = 2'd1,
        FWD_M    = 2'd2,
        FWD_E    = 2'd3
    } fwd_sel_e;

    typedef struct packed {
        logic [REG_AW_MAX-1:0] a3;
        logic                  regwrite;
        logic [TNEW_W_MAX-1:0] tnew;
    } shadow_t;

    function automatic logic src_hit(input logic [REG_AW_MAX-1:0] addr,
                                     input shadow_t s);
        return s.regwrite && (s.a3 != '0) && (s.a3 == addr);
    endfunction

    function automatic logic [TNEW_W_MAX-1:0] tnew_age(input logic [TNEW_W_MAX-1:0] t);
        return (t == '0) ? '0 : t - TNEW_W_MAX'(1);
    endfunction

    function automatic fwd_sel_e fwd_d_sel(input logic [REG_AW_MAX-1:0] addr,
                                           input shadow_t e,
                                           input shadow_t m,
                                           input shadow_t w);
        if (src_hit(addr, e) && (e.tnew == '0)) return FWD_E;
        if (src_hit(addr, m) && (m.tnew == '0)) return FWD_M;
        if (src_hit(addr, w) && (w.tnew == '0)) return FWD_W;
        return FWD_SELF;
    endfunction

    function automatic fwd_sel_e fwd_e_sel(input logic [REG_AW_MAX-1:0] addr,
                                           input shadow_t m,
                                           input shadow_t w);
        if (src_hit(addr, m) && (m.tnew == '0)) return FWD_M;
        if (src_hit(addr, w) && (w.tnew == '0)) return FWD_W;
        return FWD_SELF;
    endfunction

endpackage

// File: rtl/md_busy_counter.sv
// md_busy_counter: tracks mul/div occupancy; a start while busy is ignored.
module md_busy_counter #(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam int unsigned CW = $clog2(DIV_CYCLES + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (start && (count == '0)) begin
            count <= is_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign busy = (count != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: Tuse/Tnew stall and forward control for the 5-stage pipeline.
// Defining HAZARD_PERF_EN adds saturating stall_cycles / md_stall_cycles counters.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned TNEW_W     = 2,
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [TNEW_W-1:0] tuse_rs_d,
    input  logic [TNEW_W-1:0] tuse_rt_d,
    input  logic [REG_AW-1:0] a1_d,
    input  logic [REG_AW-1:0] a2_d,
    input  logic [REG_AW-1:0] a3_d,
    input  logic              regwrite_d,
    input  logic [TNEW_W-1:0] tnew_d,
    input  logic [REG_AW-1:0] a1_e,
    input  logic [REG_AW-1:0] a2_e,
    input  logic [REG_AW-1:0] a2_m,
    input  logic              md_use_d,
    input  logic              md_start_e,
    input  logic              md_is_div_e,
    output logic              stall,
    output logic              bubble_e,
    output logic [1:0]        f_rs_d,
    output logic [1:0]        f_rt_d,
    output logic [1:0]        f_rs_e,
    output logic [1:0]        f_rt_e,
    output logic              f_rt_m,
`ifdef HAZARD_PERF_EN
    output logic [31:0]       stall_cycles,
    output logic [31:0]       md_stall_cycles,
`endif
    output logic              md_busy
);

    shadow_t sh_e, sh_m, sh_w, sh_e_nxt;

    logic [REG_AW_MAX-1:0] a1_dx, a2_dx, a1_ex, a2_ex, a2_mx;
    logic [TNEW_W_MAX-1:0] tuse_rs_x, tuse_rt_x;
    logic                  rs_stall, rt_stall, data_stall, md_stall;

    assign a1_dx     = REG_AW_MAX'(a1_d);
    assign a2_dx     = REG_AW_MAX'(a2_d);
    assign a1_ex     = REG_AW_MAX'(a1_e);
    assign a2_ex     = REG_AW_MAX'(a2_e);
    assign a2_mx     = REG_AW_MAX'(a2_m);
    assign tuse_rs_x = TNEW_W_MAX'(tuse_rs_d);
    assign tuse_rt_x = TNEW_W_MAX'(tuse_rt_d);

    md_busy_counter #(
        .MUL_CYCLES(MUL_CYCLES),
        .DIV_CYCLES(DIV_CYCLES)
    ) u_md_busy_counter (
        .clk   (clk),
        .reset (reset),
        .start (md_start_e),
        .is_div(md_is_div_e),
        .busy  (md_busy)
    );

    // An all-ones Tuse marks the operand as unread, so it never stalls.
    always_comb begin
        rs_stall = 1'b0;
        rt_stall = 1'b0;
        if (!(&tuse_rs_d)) begin
            rs_stall = (src_hit(a1_dx, sh_e) && (sh_e.tnew > tuse_rs_x)) ||
                       (src_hit(a1_dx, sh_m) && (sh_m.tnew > tuse_rs_x));
        end
        if (!(&tuse_rt_d)) begin
            rt_stall = (src_hit(a2_dx, sh_e) && (sh_e.tnew > tuse_rt_x)) ||
                       (src_hit(a2_dx, sh_m) && (sh_m.tnew > tuse_rt_x));
        end
    end

    assign data_stall = rs_stall || rt_stall;
    assign md_stall   = md_use_d && (md_busy || md_start_e);
    assign stall      = data_stall || md_stall;
    assign bubble_e   = stall;

    assign f_rs_d = fwd_d_sel(a1_dx, sh_e, sh_m, sh_w);
    assign f_rt_d = fwd_d_sel(a2_dx, sh_e, sh_m, sh_w);
    assign f_rs_e = fwd_e_sel(a1_ex, sh_m, sh_w);
    assign f_rt_e = fwd_e_sel(a2_ex, sh_m, sh_w);
    assign f_rt_m = src_hit(a2_mx, sh_w) && (sh_w.tnew == '0);

    always_comb begin
        sh_e_nxt = '0;
        if (!stall) begin
            sh_e_nxt.a3       = REG_AW_MAX'(a3_d);
            sh_e_nxt.regwrite = regwrite_d;
            sh_e_nxt.tnew     = TNEW_W_MAX'(tnew_d);
        end
    end

    // M and W keep advancing while D is frozen; only E takes the bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_e <= '0;
            sh_m <= '0;
            sh_w <= '0;
        end else begin
            sh_e <= sh_e_nxt;
            sh_m <= '{a3: sh_e.a3, regwrite: sh_e.regwrite, tnew: tnew_age(sh_e.tnew)};
            sh_w <= '{a3: sh_m.a3, regwrite: sh_m.regwrite, tnew: '0};
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles    <= '0;
            md_stall_cycles <= '0;
        end else begin
            if (stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (md_stall && (md_stall_cycles != '1)) begin
                md_stall_cycles <= md_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule
